// File: rtl/pp_accum_normalizer.sv
// Partial-product accumulator and renormalizer.
// Each beat's denormalized partial product is aligned into a signed accumulator.
// When the group closes, the sum is renormalized to the 8-bit {S, E[4:0], M[1:0]} format.
module pp_accum_normalizer #(
  parameter int ACC_W     = 48,
  parameter int MAX_LEN   = 16,
  parameter int OUT_SHIFT = 7,
  localparam int CW       = $clog2(MAX_LEN+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_pp,
  input  logic [5:0]    in_exp,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_sat,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {ACC, NORM, OUT} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q;
  logic [CW-1:0]        count_q;
  logic                 out_valid_q;
  logic [7:0]           out_data_q;
  logic                 out_sat_q;
  logic [CW-1:0]        out_count_q;

  logic                 fire;
  logic [CW-1:0]        cnt_inc;
  logic [ACC_W-1:0]     mag_w, term_w;
  logic [ACC_W-1:0]     abs_w, sh_w;
  int                   p_i, e_i;
  logic [7:0]           norm_data;
  logic                 norm_sat;

  assign fire      = in_valid & in_ready;
  assign cnt_inc   = count_q + CW'(1);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

  // Align {L,M1,M0} by the exponent and apply the sign; L=0 is an exact zero.
  always_comb begin
    mag_w  = ACC_W'(in_pp[2:0]) << in_exp;
    term_w = '0;
    if (in_pp[2]) term_w = in_pp[3] ? -mag_w : mag_w;
  end

  // Renormalize: find the leading one of |acc|, take the next two bits truncated.
  always_comb begin
    abs_w = acc_q[ACC_W-1] ? -acc_q : acc_q;
    p_i   = 0;
    for (int i = 0; i < ACC_W; i++)
      if (abs_w[i]) p_i = i;
    e_i   = p_i - 2 - OUT_SHIFT;
    sh_w  = (p_i >= 2) ? (abs_w >> (p_i - 2)) : '0;
    norm_data = 8'h00;
    norm_sat  = 1'b0;
    if (acc_q != '0) begin
      if (e_i > 31) begin
        norm_data = {acc_q[ACC_W-1], 5'd31, 2'b11};
        norm_sat  = 1'b1;
      end else if (e_i >= 1) begin
        norm_data = {acc_q[ACC_W-1], e_i[4:0], sh_w[1:0]};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  // Next-state and input-side ready.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (fire && (in_last || cnt_inc == CW'(MAX_LEN))) state_d = NORM;
      end
      NORM: state_d = OUT;
      OUT:  if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Accumulator, beat counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        ACC: if (fire) begin
          acc_q   <= acc_q + term_w;
          count_q <= cnt_inc;
        end
        NORM: begin
          out_data_q  <= norm_data;
          out_sat_q   <= norm_sat;
          out_count_q <= count_q;
          out_valid_q <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          acc_q       <= '0;
          count_q     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_accum_normalizer.sv
// Bench for pp_accum_normalizer: directed groups plus random groups against an arithmetic model.
module tb_pp_accum_normalizer;
  localparam int ACC_W = 48, MAX_LEN = 16, OUT_SHIFT = 7, CW = $clog2(MAX_LEN+1);

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [3:0] in_pp = 0;
  logic [5:0] in_exp = 0;
  logic in_ready, out_valid, out_sat;
  logic [7:0] out_data;
  logic [CW-1:0] out_count;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pp_accum_normalizer #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp),
    .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_count(out_count));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [3:0] pp, input logic [5:0] ex, input logic last);
    int n = 0;
    assert (int'(ex) <= ACC_W-5) else $fatal(1, "illegal in_exp %0d", ex);
    in_valid = 1; in_pp = pp; in_exp = ex; in_last = last;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic get_result(input string tag, input logic [7:0] d, input logic s,
                            input logic [CW-1:0] c, input int stall);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_sat"}, out_sat, s);
    check({tag, "_count"}, out_count, c);
    out_ready = 0;
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_data"}, {out_valid, in_ready, out_data}, {1'b1, 1'b0, d});
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    check({tag, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  // Model: exact signed sum, then floor(log2) normalization with truncation.
  function automatic logic [8:0] ref_norm(input longint sum);
    longint a; int p, e; logic s; logic [1:0] m;
    if (sum == 0) return 9'h000;
    s = sum < 0;
    a = s ? -sum : sum;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    e = p - 2 - OUT_SHIFT;
    if (e < 1) return 9'h000;
    if (e > 31) return {1'b1, s, 7'h7F};
    m = 2'((a >> (p - 2)) & 3);
    return {1'b0, s, 5'(e), m};
  endfunction

  function automatic longint term(input logic [3:0] pp, input logic [5:0] ex);
    longint t;
    t = pp[2] ? (longint'(pp[2:0]) << ex) : 0;
    return pp[3] ? -t : t;
  endfunction

  initial begin
    logic [8:0] r;
    longint sum;
    int len;
    logic [3:0] pp;
    logic [5:0] ex;
    logic lst;

    // Reset state
    #23;
    check("rst_outputs", {out_valid, out_sat, out_data, 5'(out_count)}, 0);
    rst_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // Single beat with latency
    send_beat(4'b0100, 10, 1);
    check("lat_norm", {out_valid, in_ready}, 2'b00);
    tick();
    check("lat_out", out_valid, 1);
    get_result("single", 8'h0C, 0, 1, 0);

    send_beat(4'b0100, 10, 0);
    send_beat(4'b0110, 10, 1);
    get_result("two", 8'h11, 0, 2, 0);

    send_beat(4'b0100, 10, 0);
    send_beat(4'b1100, 10, 1);
    get_result("cancel", 8'h00, 0, 2, 0);

    send_beat(4'b1111, 12, 1);
    get_result("neg", 8'h97, 0, 1, 0);

    send_beat(4'b1111, 5, 1);
    get_result("uflow", 8'h00, 0, 1, 0);

    send_beat(4'b0100, 38, 0);
    send_beat(4'b0100, 38, 1);
    get_result("oflow", 8'h7F, 1, 2, 0);

    send_beat(4'b0011, 20, 0);
    send_beat(4'b0100, 10, 1);
    get_result("zero_l", 8'h0C, 0, 2, 0);

    // Auto-close at MAX_LEN, a waiting beat held upstream during backpressure
    for (int i = 0; i < MAX_LEN; i++) send_beat(4'b0100, 10, 0);
    check("autoclose_ready", in_ready, 0);
    in_valid = 1; in_pp = 4'b0111; in_exp = 20; in_last = 1;
    get_result("autoclose", 8'h1C, 0, 16, 5);
    send_beat(4'b0111, 20, 1);
    get_result("after_stall", 8'h37, 0, 1, 0);

    // Reset mid-group discards the partial sum
    send_beat(4'b0111, 30, 0);
    send_beat(4'b0111, 30, 0);
    rst_n = 0;
    #2;
    check("midrst_outputs", {out_valid, out_sat, out_data, 5'(out_count)}, 0);
    tick();
    rst_n = 1;
    #1;
    check("midrst_ready", in_ready, 1);
    send_beat(4'b0100, 10, 1);
    get_result("post_rst", 8'h0C, 0, 1, 0);

    // Random groups
    for (int g = 0; g < 12; g++) begin
      len = $urandom_range(1, MAX_LEN);
      sum = 0;
      for (int b = 0; b < len; b++) begin
        pp  = 4'($urandom_range(0, 15));
        ex  = 6'($urandom_range(0, 38));
        lst = (b == len - 1) ? ((len == MAX_LEN) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        sum += term(pp, ex);
        send_beat(pp, ex, lst);
      end
      r = ref_norm(sum);
      get_result($sformatf("rnd%0d", g), r[7:0], r[8], CW'(len), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
